// File: rtl/mem_intv_delay_buffer.sv
// -----------------------------------------------------------------------------
// mem_intv_delay_buffer
//
// Valid/ready stream buffer that sits between a processor memory port and the
// test memory. It is a circular FIFO that also enforces a minimum spacing of
// p_intv_delay cycles between outgoing (send) handshakes. Use one instance per
// direction (request path, response path).
//
// Parameters
//   p_msg_bits   : payload width (opaque to this block)
//   p_depth      : number of buffer entries, 1..16
//   p_intv_delay : minimum cycles between send handshakes, 1..255
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst_n        : asynchronous active-low reset
//   recv_msg     : incoming message
//   recv_val     : incoming message valid
//   recv_rdy     : buffer has a free entry
//   send_msg     : oldest buffered message (don't-care when empty)
//   send_val     : a message is buffered and the send interval has elapsed
//   send_rdy     : consumer accepts send_msg
//   num_entries  : current occupancy
// -----------------------------------------------------------------------------
module mem_intv_delay_buffer #(
  parameter int p_msg_bits   = 32,
  parameter int p_depth      = 2,
  parameter int p_intv_delay = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [p_msg_bits-1:0]              recv_msg,
  input  logic                               recv_val,
  output logic                               recv_rdy,
  output logic [p_msg_bits-1:0]              send_msg,
  output logic                               send_val,
  input  logic                               send_rdy,
  output logic [$clog2(p_depth+1)-1:0]       num_entries
);

  localparam int CNT_W = $clog2(p_depth + 1);
  localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(p_depth);
  localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(p_depth - 1);
  localparam logic [7:0]       ICNT_RELOAD = 8'(p_intv_delay - 1);

  // Entry storage is deliberately not reset; occupancy tracking makes stale
  // contents invisible.
  logic [p_msg_bits-1:0] mem [p_depth];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [7:0]       icnt;

  logic recv_fire;
  logic send_fire;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // recv_rdy depends only on registered occupancy, so there is no
  // combinational path from send_rdy; a full buffer refuses a message even
  // in a cycle where it also sends.
  assign recv_rdy    = (count != FULL_CNT);
  assign send_val    = (count != '0) && (icnt == 8'd0);
  assign send_msg    = mem[head];
  assign num_entries = count;

  assign recv_fire = recv_val && recv_rdy;
  assign send_fire = send_val && send_rdy;

  always_ff @(posedge clk) begin
    if (recv_fire) begin
      mem[tail] <= recv_msg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      icnt  <= 8'd0;
    end else begin
      if (recv_fire) begin
        tail <= ptr_next(tail);
      end
      if (send_fire) begin
        head <= ptr_next(head);
      end

      case ({recv_fire, send_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // The interval is measured from the last send handshake and keeps
      // counting down while empty, so a late arrival is not delayed further.
      if (send_fire) begin
        icnt <= ICNT_RELOAD;
      end else if (icnt != 8'd0) begin
        icnt <= icnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_intv_delay_buffer.sv
// -----------------------------------------------------------------------------
// Testbench for mem_intv_delay_buffer. Two instances share the same stimulus:
//   dut_a : p_depth=2, p_intv_delay=1
//   dut_b : p_depth=4, p_intv_delay=3
// A queue-based reference model tracks each instance every cycle; directed
// tables and sequences add explicit expectations on top.
// -----------------------------------------------------------------------------
module tb_mem_intv_delay_buffer;

  logic        clk;
  logic        rst_n;
  logic [31:0] recv_msg;
  logic        recv_val;
  logic        send_rdy;

  logic        a_recv_rdy, a_send_val;
  logic [31:0] a_send_msg;
  logic [1:0]  a_num;
  logic        b_recv_rdy, b_send_val;
  logic [31:0] b_send_msg;
  logic [2:0]  b_num;

  mem_intv_delay_buffer #(.p_msg_bits(32), .p_depth(2), .p_intv_delay(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(a_recv_rdy),
    .send_msg(a_send_msg), .send_val(a_send_val), .send_rdy(send_rdy),
    .num_entries(a_num)
  );

  mem_intv_delay_buffer #(.p_msg_bits(32), .p_depth(4), .p_intv_delay(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(b_recv_rdy),
    .send_msg(b_send_msg), .send_val(b_send_val), .send_rdy(send_rdy),
    .num_entries(b_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          last_a, last_b;
  int          cyc = 0;
  bit          hr_a, hs_a, hr_b, hs_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Called at posedge+1 with inputs already driven: compare both instances
  // against the model at mid-cycle and latch the handshakes the model predicts.
  task automatic sample();
    bit rr, sv;
    #4;
    rr = (qa.size() != 2);
    sv = (qa.size() != 0) && ((cyc - last_a) >= 1);
    chk("a_recv_rdy", 32'(a_recv_rdy), 32'(rr));
    chk("a_send_val", 32'(a_send_val), 32'(sv));
    chk("a_num_entries", 32'(a_num), 32'(qa.size()));
    if (sv) chk("a_send_msg", a_send_msg, qa[0]);
    hr_a = recv_val && rr;
    hs_a = sv && send_rdy;

    rr = (qb.size() != 4);
    sv = (qb.size() != 0) && ((cyc - last_b) >= 3);
    chk("b_recv_rdy", 32'(b_recv_rdy), 32'(rr));
    chk("b_send_val", 32'(b_send_val), 32'(sv));
    chk("b_num_entries", 32'(b_num), 32'(qb.size()));
    if (sv) chk("b_send_msg", b_send_msg, qb[0]);
    hr_b = recv_val && rr;
    hs_b = sv && send_rdy;
  endtask

  // Cross the rising edge and apply the latched handshakes to the model.
  task automatic advance();
    logic [31:0] m;
    m = recv_msg;
    @(posedge clk);
    #1;
    if (hs_a) begin void'(qa.pop_front()); last_a = cyc; end
    if (hr_a) qa.push_back(m);
    if (hs_b) begin void'(qb.pop_front()); last_b = cyc; end
    if (hr_b) qb.push_back(m);
    cyc++;
  endtask

  // Assert reset mid-cycle (async), check outputs before any edge, release at
  // the next posedge+1 and clear the model (no pending interval).
  task automatic do_reset();
    rst_n    = 1'b0;
    recv_val = 1'b0;
    send_rdy = 1'b0;
    #2;
    chk("rst_a_recv_rdy", 32'(a_recv_rdy), 32'd1);
    chk("rst_a_send_val", 32'(a_send_val), 32'd0);
    chk("rst_a_num", 32'(a_num), 32'd0);
    chk("rst_b_send_val", 32'(b_send_val), 32'd0);
    chk("rst_b_num", 32'(b_num), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    qa.delete();
    qb.delete();
    last_a = -1000;
    last_b = -1000;
    cyc++;
  endtask

  typedef struct {
    bit          rst_before;
    bit          rv;
    logic [31:0] msg;
    bit          sr;
    bit          e_rr;
    bit          e_sv;
    logic [31:0] e_msg;
    int          e_num;
  } vec_t;

  vec_t tbl[11];

  int          hs_cyc[$];
  int          t0;
  int          acc, sent, n;
  bit          prev_stall;
  logic [31:0] prev_msg;

  initial begin
    // Streaming through dut_a, then fill/drain with backpressure.
    tbl[0]  = '{1'b1, 1'b1, 32'hA, 1'b1, 1'b1, 1'b0, 32'h0, 0};
    tbl[1]  = '{1'b0, 1'b1, 32'hB, 1'b1, 1'b1, 1'b1, 32'hA, 1};
    tbl[2]  = '{1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 32'hB, 1};
    tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hC, 1};
    tbl[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 0};
    tbl[5]  = '{1'b1, 1'b1, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0, 0};
    tbl[6]  = '{1'b0, 1'b1, 32'h2, 1'b0, 1'b1, 1'b1, 32'h1, 1};
    tbl[7]  = '{1'b0, 1'b1, 32'h3, 1'b0, 1'b0, 1'b1, 32'h1, 2};
    tbl[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1, 2};
    tbl[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h2, 1};
    tbl[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 0};

    rst_n    = 1'b0;
    recv_val = 1'b0;
    recv_msg = 32'h0;
    send_rdy = 1'b0;
    last_a   = -1000;
    last_b   = -1000;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst_before) do_reset();
      recv_val = tbl[i].rv;
      recv_msg = tbl[i].msg;
      send_rdy = tbl[i].sr;
      sample();
      chk($sformatf("tbl%0d_recv_rdy", i), 32'(a_recv_rdy), 32'(tbl[i].e_rr));
      chk($sformatf("tbl%0d_send_val", i), 32'(a_send_val), 32'(tbl[i].e_sv));
      chk($sformatf("tbl%0d_num", i), 32'(a_num), 32'(tbl[i].e_num));
      if (tbl[i].e_sv) chk($sformatf("tbl%0d_send_msg", i), a_send_msg, tbl[i].e_msg);
      advance();
    end

    // Simultaneous recv/send at occupancy 1 on dut_a, pointers wrap 5 times.
    do_reset();
    recv_val = 1'b1; recv_msg = 32'd100; send_rdy = 1'b0;
    sample(); advance();
    for (int i = 0; i < 10; i++) begin
      recv_val = 1'b1; recv_msg = 32'd101 + 32'(i); send_rdy = 1'b1;
      sample();
      chk("simul_num", 32'(a_num), 32'd1);
      chk("simul_recv_rdy", 32'(a_recv_rdy), 32'd1);
      chk("simul_send_val", 32'(a_send_val), 32'd1);
      chk("simul_send_msg", a_send_msg, 32'd100 + 32'(i));
      advance();
    end

    // Interval spacing on dut_b (delay 3): four buffered messages leave at
    // t, t+3, t+6, t+9.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      recv_val = 1'b1; recv_msg = 32'd200 + 32'(i); send_rdy = 1'b0;
      sample(); advance();
    end
    recv_val = 1'b0; send_rdy = 1'b1;
    hs_cyc.delete();
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      sample();
      if (i == 0) chk("intv_b_full", 32'(b_num), 32'd4);
      if (b_send_val && send_rdy) hs_cyc.push_back(cyc);
      advance();
    end
    chk("intv_count", 32'(hs_cyc.size()), 32'd4);
    if (hs_cyc.size() > 0) chk("intv_first", 32'(hs_cyc[0]), 32'(t0));
    for (int i = 1; i < hs_cyc.size(); i++)
      chk($sformatf("intv_gap%0d", i), 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);

    // Mid-operation reset on dut_b with two entries and a pending interval.
    do_reset();
    recv_val = 1'b1; recv_msg = 32'd300; send_rdy = 1'b1; sample(); advance();
    recv_val = 1'b1; recv_msg = 32'd301; send_rdy = 1'b0; sample(); advance();
    recv_val = 1'b1; recv_msg = 32'd302; send_rdy = 1'b1; sample(); advance();
    recv_val = 1'b0; send_rdy = 1'b0;
    sample();
    chk("midrst_b_num_before", 32'(b_num), 32'd2);
    chk("midrst_b_val_before", 32'(b_send_val), 32'd0);
    do_reset();
    sample();
    chk("midrst_b_val_after", 32'(b_send_val), 32'd0);
    chk("midrst_b_num_after", 32'(b_num), 32'd0);
    chk("midrst_b_rdy_after", 32'(b_recv_rdy), 32'd1);
    advance();
    recv_val = 1'b1; recv_msg = 32'h5; send_rdy = 1'b1;
    sample(); advance();
    recv_val = 1'b0;
    sample();
    chk("midrst_b_new_val", 32'(b_send_val), 32'd1);
    chk("midrst_b_new_msg", b_send_msg, 32'h5);
    chk("midrst_a_new_msg", a_send_msg, 32'h5);
    advance();

    // Random traffic with random backpressure; model checks order and payload.
    do_reset();
    acc = 0; sent = 0; n = 0; prev_stall = 1'b0; prev_msg = '0;
    while (acc < 200 && n < 4000) begin
      recv_val = ($urandom_range(0, 3) != 0);
      recv_msg = $urandom;
      send_rdy = $urandom_range(0, 1);
      sample();
      if (prev_stall) chk("stall_stable_a", a_send_msg, prev_msg);
      prev_stall = a_send_val && !send_rdy;
      prev_msg   = a_send_msg;
      if (hr_a) acc++;
      if (hs_a) sent++;
      advance();
      n++;
    end
    chk("rand_accept_budget", 32'(acc), 32'd200);
    recv_val = 1'b0; send_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      sample();
      if (hs_a) sent++;
      advance();
    end
    chk("rand_a_sent_total", 32'(sent), 32'd200);
    chk("rand_a_drained", 32'(a_num), 32'd0);
    chk("rand_b_drained", 32'(b_num), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
